// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_wr_arbiter_pkg
//   Shared definitions for the SA-array write path: the FIFO entry layout
//   (addr, data) and the default downstream FIFO depth. Imported by the FIFO
//   and by fifo_wr_arbiter so both sides agree on entry format and depth.
package fifo_wr_arbiter_pkg;

  localparam int unsigned ADDR_W         = 8;
  localparam int unsigned DATA_W         = 16;
  localparam int unsigned DEF_FIFO_DEPTH = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } FIFO_ENTRY_t;

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// fifo_wr_arbiter_rr_picker
//   Combinational round-robin picker: grants the first set bit of req at or
//   after ptr, wrapping modulo N. Shared with the read-side scheduler.
// Ports:
//   req   in  N   request vector
//   ptr   in  IW  search start index
//   grant out N   one-hot grant (all zero when req is zero)
//   idx   out IW  index of the granted bit (0 when req is zero)
module fifo_wr_arbiter_rr_picker #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  always_comb begin
    logic        found;
    int unsigned cand;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned off = 0; off < N; off++) begin
      cand = 32'(ptr) + off;
      cand = cand % N;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin write-side arbiter sharing one FIFO among NUM_REQ producers.
//   A requester keeps the grant for up to MAX_BURST consecutive beats. A
//   credit counter mirrors FIFO occupancy so the FIFO is never overfilled.
// Ports:
//   clk, rst      clock; synchronous active-high reset (shared with FIFO)
//   req_valid     per-requester beat valid
//   req_entry     per-requester beat (addr, data)
//   req_ready     per-requester accept, at most one bit high
//   fifo_wr_en    registered FIFO write enable
//   fifo_data_in  registered FIFO write data
//   fifo_rd_en    consumer read enable
//   fifo_empty    FIFO empty flag
//   credit_cnt    free FIFO slots not yet claimed
//   grant_id      index of the current grant holder (debug)
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_REQ    = 4,
  parameter  int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter  int unsigned MAX_BURST  = 4,
  localparam int unsigned IDX_W      = $clog2(NUM_REQ),
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  FIFO_ENTRY_t [NUM_REQ-1:0] req_entry,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      fifo_wr_en,
  output FIFO_ENTRY_t               fifo_data_in,
  input  logic                      fifo_rd_en,
  input  logic                      fifo_empty,
  output logic [CNT_W-1:0]          credit_cnt,
  output logic [IDX_W-1:0]          grant_id
);

  localparam int unsigned BEAT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   credit_q, credit_d;
  logic               wr_en_q, wr_en_d;
  FIFO_ENTRY_t        data_q, data_d;

  logic [IDX_W-1:0]   pick_ptr;
  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   gnt_idx;
  logic [IDX_W-1:0]   owner_next;
  logic               owner_hold;
  logic               accept;
  logic               pop;

  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + IDX_W'(1);
  endfunction

  assign owner_hold = (state_q == BURST) && req_valid[owner_q];
  assign owner_next = idx_inc(owner_q);

  // A burst whose owner dropped valid is released in the same cycle, so the
  // picker already searches from owner+1 while the registered state is BURST.
  assign pick_ptr = (state_q == BURST) ? owner_next : rr_ptr_q;

  fifo_wr_arbiter_rr_picker #(
    .N (NUM_REQ)
  ) u_rr_picker (
    .req   (req_valid),
    .ptr   (pick_ptr),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  always_comb begin
    grant   = pick_grant;
    gnt_idx = pick_idx;
    if (owner_hold) begin
      grant   = NUM_REQ'(1) << owner_q;
      gnt_idx = owner_q;
    end
  end

  // Ready uses only the registered credit, never the live pop.
  assign req_ready = grant & {NUM_REQ{credit_q != '0}};
  assign accept    = |(req_valid & req_ready);
  assign pop       = fifo_rd_en && !fifo_empty;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    if (owner_hold) begin
      if (accept) begin
        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
        if (beat_cnt_q + BEAT_W'(1) == BEAT_W'(MAX_BURST)) begin
          state_d  = IDLE;
          rr_ptr_d = owner_next;
        end
      end
    end else begin
      if (state_q == BURST) begin
        state_d  = IDLE;
        rr_ptr_d = owner_next;
      end
      if (accept) begin
        owner_d    = pick_idx;
        beat_cnt_d = BEAT_W'(1);
        if (MAX_BURST == 1) begin
          state_d  = IDLE;
          rr_ptr_d = idx_inc(pick_idx);
        end else begin
          state_d  = BURST;
        end
      end
    end
  end

  always_comb begin
    credit_d = credit_q;
    if (accept && !pop) begin
      credit_d = credit_q - CNT_W'(1);
    end else if (pop && !accept && credit_q != CNT_W'(FIFO_DEPTH)) begin
      credit_d = credit_q + CNT_W'(1);
    end
  end

  always_comb begin
    wr_en_d = accept;
    data_d  = accept ? req_entry[gnt_idx] : data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      beat_cnt_q <= '0;
      rr_ptr_q   <= '0;
      credit_q   <= CNT_W'(FIFO_DEPTH);
      wr_en_q    <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      credit_q   <= credit_d;
      wr_en_q    <= wr_en_d;
      data_q     <= data_d;
    end
  end

  assign fifo_wr_en   = wr_en_q;
  assign fifo_data_in = data_q;
  assign credit_cnt   = credit_q;
  assign grant_id     = gnt_idx;

  // A pop while every slot is still unclaimed means the FIFO and this
  // counter disagree; the counter saturates instead of overflowing.
  a_no_pop_when_unclaimed : assert property (@(posedge clk) disable iff (rst)
    !(pop && !accept && credit_q == CNT_W'(FIFO_DEPTH)));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
//   Directed self-checking bench for fifo_wr_arbiter (NUM_REQ=4, depth 8,
//   MAX_BURST=4). A small occupancy model stands in for the FIFO and drives
//   fifo_empty.
module tb_fifo_wr_arbiter;
  import fifo_wr_arbiter_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [3:0]        req_valid = '0;
  FIFO_ENTRY_t [3:0] req_entry = '0;
  logic [3:0]        req_ready;
  logic              fifo_wr_en;
  FIFO_ENTRY_t       fifo_data_in;
  logic              fifo_rd_en = 1'b0;
  logic              fifo_empty;
  logic [3:0]        credit_cnt;
  logic [1:0]        grant_id;

  int n_tests = 0;
  int n_fail  = 0;
  int occ     = 0;

  fifo_wr_arbiter #(
    .NUM_REQ    (4),
    .FIFO_DEPTH (8),
    .MAX_BURST  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_entry    (req_entry),
    .req_ready    (req_ready),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_data_in (fifo_data_in),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_empty   (fifo_empty),
    .credit_cnt   (credit_cnt),
    .grant_id     (grant_id)
  );

  always #5 clk = ~clk;

  // FIFO occupancy: writes land on the edge where fifo_wr_en is high.
  always @(posedge clk) begin
    if (rst) occ <= 0;
    else     occ <= occ + (fifo_wr_en ? 1 : 0) - ((fifo_rd_en && occ != 0) ? 1 : 0);
  end
  assign fifo_empty = (occ == 0);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Claimed slots are either in the FIFO or in the registered write stage.
  task automatic check_credit_inv(input string tag);
    check_eq(tag, 32'(credit_cnt), 32'(8 - occ - (fifo_wr_en ? 1 : 0)));
  endtask

  function automatic FIFO_ENTRY_t mk(input int r, input int a);
    FIFO_ENTRY_t e;
    e.addr = 8'(a);
    e.data = 16'(16'hC000 + r * 256 + a);
    return e;
  endfunction

  task automatic do_reset();
    rst        = 1'b1;
    req_valid  = '0;
    fifo_rd_en = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev_credit;
    int exp_idx;

    // Reset state
    #1;
    tick();
    tick();
    check_eq("rst_ready",  32'(req_ready),    32'h0);
    check_eq("rst_wr_en",  32'(fifo_wr_en),   32'h0);
    check_eq("rst_data",   32'(fifo_data_in), 32'h0);
    check_eq("rst_credit", 32'(credit_cnt),   32'd8);
    check_eq("rst_gid",    32'(grant_id),     32'd0);
    rst = 1'b0;

    // Single requester fills the FIFO, no pops
    for (int k = 0; k < 10; k++) begin
      req_valid    = 4'b0100;
      req_entry[2] = mk(2, k);
      #1;
      check_eq("t1_ready", 32'(req_ready), (k < 8) ? 32'h4 : 32'h0);
      check_eq("t1_gid",   32'(grant_id),  32'd2);
      tick();
      check_eq("t1_wr_en",   32'(fifo_wr_en),        (k < 8) ? 32'd1 : 32'd0);
      check_eq("t1_addr",    32'(fifo_data_in.addr), (k < 8) ? 32'(k) : 32'd7);
      check_eq("t1_credit",  32'(credit_cnt),        (k < 8) ? 32'(7 - k) : 32'd0);
      check_credit_inv("t1_inv");
    end
    check_eq("t1_full", 32'(occ), 32'd8);

    // All requesters valid, consumer pops every cycle
    do_reset();
    fifo_rd_en  = 1'b1;
    prev_credit = 8;
    for (int b = 0; b < 20; b++) begin
      req_valid = 4'b1111;
      for (int i = 0; i < 4; i++) req_entry[i] = mk(i, b);
      exp_idx = (b / 4) % 4;
      #1;
      check_eq("t2_ready", 32'(req_ready), 32'(1 << exp_idx));
      check_eq("t2_gid",   32'(grant_id),  32'(exp_idx));
      tick();
      check_eq("t2_data", 32'(fifo_data_in), 32'(mk(exp_idx, b)));
      check_credit_inv("t2_inv");
      if (b >= 2) check_eq("t2_steady", 32'(credit_cnt), 32'(prev_credit));
      prev_credit = int'(credit_cnt);
    end

    // Owner drops valid mid-burst; next requester granted in the same cycle
    do_reset();
    for (int c = 0; c < 3; c++) begin
      req_valid    = (c < 2) ? 4'b0011 : 4'b0010;
      req_entry[0] = mk(0, c);
      req_entry[1] = mk(1, c);
      #1;
      check_eq("t3_ready", 32'(req_ready), (c < 2) ? 32'h1 : 32'h2);
      tick();
    end
    check_eq("t3_data",  32'(fifo_data_in), 32'(mk(1, 2)));
    check_eq("t3_rrptr", 32'(dut.rr_ptr_q), 32'd1);
    check_eq("t3_owner", 32'(dut.owner_q),  32'd1);

    // credit_cnt==1 with a same-cycle accept and pop
    do_reset();
    for (int k = 0; k < 7; k++) begin
      req_valid    = 4'b0001;
      req_entry[0] = mk(0, k);
      tick();
    end
    req_valid = 4'b0000;
    tick();
    check_eq("t4_credit1", 32'(credit_cnt), 32'd1);
    check_credit_inv("t4_inv");
    req_valid  = 4'b0001;
    fifo_rd_en = 1'b1;
    #1;
    check_eq("t4_ready", 32'(req_ready), 32'h1);
    tick();
    fifo_rd_en = 1'b0;
    check_eq("t4_credit_hold", 32'(credit_cnt), 32'd1);
    #1;
    check_eq("t4_ready_next", 32'(req_ready), 32'h1);

    // credit_cnt==0 in a burst, then a pop restores ready one cycle later
    tick();
    check_eq("t5_credit0", 32'(credit_cnt), 32'd0);
    check_eq("t5_ready0",  32'(req_ready),  32'h0);
    check_eq("t5_beat",    32'(dut.beat_cnt_q), 32'd2);
    tick();
    check_eq("t5_ready_held", 32'(req_ready),      32'h0);
    check_eq("t5_beat_held",  32'(dut.beat_cnt_q), 32'd2);
    fifo_rd_en = 1'b1;
    #1;
    check_eq("t5_no_comb_path", 32'(req_ready), 32'h0);
    tick();
    fifo_rd_en = 1'b0;
    check_eq("t5_ready_back", 32'(req_ready),      32'h1);
    check_eq("t5_credit_pop", 32'(credit_cnt),     32'd1);
    check_eq("t5_beat_kept",  32'(dut.beat_cnt_q), 32'd2);
    check_eq("t5_owner_kept", 32'(dut.owner_q),    32'd0);
    check_eq("t5_gid",        32'(grant_id),       32'd0);

    // Reset mid-operation
    do_reset();
    for (int k = 0; k < 5; k++) begin
      req_valid    = 4'b1000;
      req_entry[3] = mk(3, k);
      tick();
    end
    check_eq("t6_pre_credit", 32'(credit_cnt), 32'd3);
    check_eq("t6_pre_wr_en",  32'(fifo_wr_en), 32'd1);
    rst       = 1'b1;
    req_valid = 4'b1111;
    tick();
    check_eq("t6_wr_en",   32'(fifo_wr_en),   32'd0);
    check_eq("t6_credit",  32'(credit_cnt),   32'd8);
    check_eq("t6_data",    32'(fifo_data_in), 32'h0);
    rst = 1'b0;
    #1;
    check_eq("t6_ready", 32'(req_ready), 32'h1);
    check_eq("t6_gid",   32'(grant_id),  32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
